// File: rtl/multibyte_sub_sequencer_if.sv
// Bus bundle for the multi-byte subtraction sequencer: request/response
// handshake plus the byte-wide link to the external ripple-borrow stage.
//
// Handshake: the requester raises start with op_a/op_b/borrow_in valid; the
// sequencer accepts on the first rising edge where it is idle (busy low) and
// start is high. Requests arriving while busy is high are dropped, not queued.
// done is a one-cycle pulse marking result/borrow_out/zero/ovf valid; those
// outputs then hold until the next operation begins capturing bytes.
interface multibyte_sub_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  // request side
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         borrow_in;
  // response side
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         borrow_out;
  logic         zero;
  logic         ovf;
  // subtractor stage link
  logic [7:0]   sub_x;
  logic [7:0]   sub_y;
  logic         sub_bin;
  logic [7:0]   sub_diff;
  logic         sub_bout;
  // FSM state for observation
  logic [1:0]   state_dbg;

  // Requester and subtractor-stage side
  modport master (
    output start, op_a, op_b, borrow_in, sub_diff, sub_bout,
    input  busy, done, result, borrow_out, zero, ovf,
    input  sub_x, sub_y, sub_bin, state_dbg
  );

  // Sequencer side
  modport slave (
    input  start, op_a, op_b, borrow_in, sub_diff, sub_bout,
    output busy, done, result, borrow_out, zero, ovf,
    output sub_x, sub_y, sub_bin, state_dbg
  );
endinterface

// File: rtl/multibyte_sub_sequencer.sv
// Byte-serial NBYTES-wide subtractor controller. Drives an external 8-bit
// ripple-borrow stage one byte per cycle (LSB first), chaining the borrow
// through a register, and presents a registered wide result with flags.
module multibyte_sub_sequencer #(
  parameter int NBYTES = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  multibyte_sub_sequencer_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            brw_q, brw_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            borrow_out_q, borrow_out_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;

  logic            last_byte;
  logic [W-1:0]    capt_result;
  logic            busy_c, done_c, sub_bin_c;
  logic [7:0]      sub_x_c, sub_y_c;

  assign last_byte = (state_q == S_RUN) && (idx_q == IW'(NBYTES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start is only looked at while idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_byte) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: status plus operand bytes to the stage, zero outside RUN
  always_comb begin
    busy_c    = (state_q != S_IDLE);
    done_c    = (state_q == S_DONE);
    sub_x_c   = 8'h00;
    sub_y_c   = 8'h00;
    sub_bin_c = 1'b0;
    if (state_q == S_RUN) begin
      sub_x_c   = a_q[8*idx_q +: 8];
      sub_y_c   = b_q[8*idx_q +: 8];
      sub_bin_c = brw_q;
    end
  end

  // Result with the current stage difference merged into the active byte
  always_comb begin
    capt_result                = result_q;
    capt_result[8*idx_q +: 8]  = bus.sub_diff;
  end

  // Datapath next values: latch on accept, capture a byte per RUN cycle,
  // and register the flags from the fully assembled result on the last byte
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    brw_d        = brw_q;
    idx_d        = idx_q;
    result_d     = result_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.op_a;
          b_d   = bus.op_b;
          brw_d = bus.borrow_in;
          idx_d = '0;
        end
      end
      S_RUN: begin
        result_d = capt_result;
        brw_d    = bus.sub_bout;
        idx_d    = idx_q + 1'b1;
        if (last_byte) begin
          borrow_out_d = bus.sub_bout;
          zero_d       = (capt_result == '0);
          // overflow: operand signs differ and the result sign differs from A
          ovf_d        = (a_q[W-1] != b_q[W-1]) && (capt_result[W-1] != a_q[W-1]);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      brw_q        <= 1'b0;
      idx_q        <= '0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      brw_q        <= brw_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.result     = result_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.zero       = zero_q;
  assign bus.ovf        = ovf_q;
  assign bus.sub_x      = sub_x_c;
  assign bus.sub_y      = sub_y_c;
  assign bus.sub_bin    = sub_bin_c;
  assign bus.state_dbg  = state_q;

endmodule
